// File: rtl/clock_divider_pkg.sv
// Shared definitions for the clock divider bank.
//   MAX_CHANNELS    : upper bound on the CHANNELS parameter
//   DEFAULT_DIVISOR : divisor every channel comes out of reset with
//   ceil_half()     : number of high cycles for a divisor D (ceil(D/2))
package clock_divider_pkg;

  localparam int MAX_CHANNELS    = 16;
  localparam int DEFAULT_DIVISOR = 3;

  // Divisors are handled as 32-bit quantities here, so WIDTH is limited to 32.
  function automatic logic [31:0] ceil_half(input logic [31:0] d);
    return (d >> 1) + {31'd0, d[0]};
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter 0..D-1, shadow (pending) divisor, registered
// square-wave and tick outputs.
//   clock_in, reset : clock, synchronous active-high reset
//   en_i            : run enable; low holds counter at 0 and outputs low
//   restart_i       : phase-align (counter to 0, pending divisor applied)
//   wr_i, wr_div_i  : validated divisor write for this channel
//   pend_o          : a pending divisor is waiting for the next wrap
//   clk_o, tick_o   : divided clock, one-cycle pulse per period
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int WIDTH       = 23,
  parameter int DEFAULT_DIV = DEFAULT_DIVISOR
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_div_i,
  output logic             pend_o,
  output logic             clk_o,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, shd_q, shd_d;
  logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
  logic             wrap, hold;

  assign wrap = (cnt_q == div_q - WIDTH'(1));
  assign hold = restart_i | ~en_i;

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    clk_d  = 1'b0;
    tick_d = 1'b0;
    if (hold) begin
      // Parked or restarting: nothing is mid-period, so a new divisor
      // (including one written this very cycle) can take effect at once.
      cnt_d = '0;
      if (wr_i) begin
        div_d  = wr_div_i;
        pend_d = 1'b0;
      end else if (pend_q) begin
        div_d  = shd_q;
        pend_d = 1'b0;
      end
    end else begin
      clk_d  = 32'(cnt_q) < ceil_half(32'(div_q));
      tick_d = wrap;
      if (wrap) begin
        cnt_d = '0;
        if (pend_q) begin
          div_d  = shd_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
      // A write is only accepted while pend_q is clear, so it cannot collide
      // with the swap above; a write landing on the wrap waits a full period.
      if (wr_i) begin
        shd_d  = wr_div_i;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt_q  <= '0;
      div_q  <= WIDTH'(DEFAULT_DIV);
      shd_q  <= '0;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign pend_o = pend_q;
  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of CHANNELS independent programmable clock dividers sharing one
// divisor-write port.
//   clock_in, reset          : clock, synchronous active-high reset
//   cfg_valid/cfg_ready      : divisor write handshake
//   cfg_chan, cfg_div        : target channel and new divisor
//   enable                   : per-channel run enable
//   sync_restart             : restart all channels in phase
//   clock_out, tick          : per-channel divided clock and period pulse
//   cfg_err                  : pulse after an accepted but invalid write
module clock_divider_bank
  import clock_divider_pkg::*;
#(
  parameter int  CHANNELS    = 4,
  parameter int  WIDTH       = 23,
  parameter int  DEFAULT_DIV = DEFAULT_DIVISOR,
  localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync_restart,
  output logic [CHANNELS-1:0] clock_out,
  output logic [CHANNELS-1:0] tick,
  output logic                cfg_err
);

  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("clock_divider_bank: CHANNELS out of range");
  end

  logic [CHANNELS-1:0] hit, pend, wr;
  logic                accept, bad, cfg_err_q;

  // hit is one-hot on an in-range address and all zero otherwise, so it
  // doubles as the range check without indexing past the channel vector.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_hit
    assign hit[i] = (cfg_chan == CW'(i));
  end

  assign cfg_ready = ~|(hit & pend);
  assign accept    = cfg_valid & cfg_ready;
  assign bad       = (cfg_div == '0) | ~|hit;
  assign wr        = {CHANNELS{accept & ~bad}} & hit;

  always_ff @(posedge clock_in) begin
    if (reset) cfg_err_q <= 1'b0;
    else       cfg_err_q <= accept & bad;
  end
  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    clock_divider_channel #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clock_in (clock_in),
      .reset    (reset),
      .en_i     (enable[i]),
      .restart_i(sync_restart),
      .wr_i     (wr[i]),
      .wr_div_i (cfg_div),
      .pend_o   (pend[i]),
      .clk_o    (clock_out[i]),
      .tick_o   (tick[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
module tb_clock_divider_bank;
  localparam int CH = 5;
  localparam int W  = 23;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, cv, sr;
  logic [CW-1:0] cc;
  logic [W-1:0]  cd;
  logic [CH-1:0] en;
  logic          cfg_ready, cfg_err;
  logic [CH-1:0] clock_out, tick;

  int errors = 0;
  int checks = 0;

  // Reference model: divisor, pending divisor/flag, position within period.
  int            m_cnt[CH], m_d[CH], m_pd[CH];
  bit            m_pf[CH];
  logic [CH-1:0] e_clk, e_tick;
  logic          e_err;

  always #5 clk = ~clk;

  clock_divider_bank #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(3)) dut (
    .clock_in(clk), .reset(rst), .cfg_valid(cv), .cfg_ready(cfg_ready),
    .cfg_chan(cc), .cfg_div(cd), .enable(en), .sync_restart(sr),
    .clock_out(clock_out), .tick(tick), .cfg_err(cfg_err)
  );

  function automatic bit m_ready();
    if (int'(cc) >= CH) return 1'b1;
    return !m_pf[int'(cc)];
  endfunction

  // Advance the model with the current inputs, then clock the DUT.
  task automatic step();
    bit acc, bad;
    acc = cv && m_ready();
    bad = (cd == 0) || (int'(cc) >= CH);
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_cnt[i] = 0; m_d[i] = 3; m_pd[i] = 0; m_pf[i] = 0;
      end
      e_clk = '0; e_tick = '0; e_err = 1'b0;
    end else begin
      e_err = acc && bad;
      for (int i = 0; i < CH; i++) begin
        bit w;
        w = acc && !bad && (int'(cc) == i);
        if (sr || !en[i]) begin
          e_clk[i] = 1'b0; e_tick[i] = 1'b0; m_cnt[i] = 0;
          if (w) begin m_d[i] = int'(cd); m_pf[i] = 0; end
          else if (m_pf[i]) begin m_d[i] = m_pd[i]; m_pf[i] = 0; end
        end else begin
          e_clk[i]  = (m_cnt[i] < (m_d[i] + 1) / 2);
          e_tick[i] = (m_cnt[i] == m_d[i] - 1);
          m_cnt[i]  = (m_cnt[i] + 1) % m_d[i];
          if (m_cnt[i] == 0 && m_pf[i]) begin m_d[i] = m_pd[i]; m_pf[i] = 0; end
          if (w) begin m_pd[i] = int'(cd); m_pf[i] = 1; end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; cv = 0; sr = 0; cc = 0; cd = 0; en = '0;
    step(); step();
    rst = 0; en = '0;
    #1;
    checks++; if (clock_out !== '0) begin errors++; $display("FAIL reset_clk: got %b want 0", clock_out); end
    checks++; if (tick !== '0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", cfg_err); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
    rst = 1;
    step();
  endtask

  task automatic test_default();
    en = '1; rst = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      checks++;
      if (clock_out[0] !== (k % 3 != 0)) begin
        errors++; $display("FAIL default_clk cyc %0d: got %b want %b", k, clock_out[0], k % 3 != 0);
      end
      checks++;
      if (tick[0] !== (k % 3 == 0)) begin
        errors++; $display("FAIL default_tick cyc %0d: got %b want %b", k, tick[0], k % 3 == 0);
      end
      checks++;
      if ({clock_out, tick, cfg_err, cfg_ready} !== {e_clk, e_tick, e_err, m_ready()}) begin
        errors++; $display("FAIL default_model: clk %b/%b tick %b/%b err %b/%b", clock_out, e_clk, tick, e_tick, cfg_err, e_err);
      end
    end
  endtask

  task automatic test_reconfig();
    int guard;
    step();
    cv = 1; cc = 1; cd = 4;
    step();
    cv = 0; #1;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reconfig_busy: got %b want 0", cfg_ready); end
    guard = 0;
    while (m_pf[1] && guard < 20) begin
      step(); guard++;
      checks++;
      if ({clock_out, tick, cfg_ready} !== {e_clk, e_tick, m_ready()}) begin
        errors++; $display("FAIL reconfig_old: clk %b/%b tick %b/%b rdy %b/%b", clock_out, e_clk, tick, e_tick, cfg_ready, m_ready());
      end
    end
    checks++; if (guard >= 20) begin errors++; $display("FAIL reconfig_wrap: got no wrap want wrap within 20"); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reconfig_ready: got %b want 1", cfg_ready); end
    for (int j = 0; j < 8; j++) begin
      step();
      checks++;
      if (clock_out[1] !== (j % 4 < 2)) begin
        errors++; $display("FAIL reconfig_d4 step %0d: got %b want %b", j, clock_out[1], j % 4 < 2);
      end
    end
  endtask

  task automatic test_errors();
    logic [CW-1:0] chans [3];
    logic [W-1:0]  divs [3];
    chans[0] = 0; divs[0] = 0;
    chans[1] = 5; divs[1] = 7;
    chans[2] = 7; divs[2] = 2;
    for (int t = 0; t < 3; t++) begin
      cv = 1; cc = chans[t]; cd = divs[t];
      step();
      cv = 0; #1;
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_pulse %0d: got %b want 1", t, cfg_err); end
      step();
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_once %0d: got %b want 0", t, cfg_err); end
      checks++;
      if ({clock_out, tick} !== {e_clk, e_tick}) begin
        errors++; $display("FAIL err_outputs %0d: clk %b/%b tick %b/%b", t, clock_out, e_clk, tick, e_tick);
      end
    end
  endtask

  task automatic test_sync_restart();
    cv = 1; cc = 1; cd = 5; sr = 1;
    step();
    cv = 0; sr = 0; #1;
    checks++; if (clock_out[1:0] !== 2'b00) begin errors++; $display("FAIL restart_low: got %b want 00", clock_out[1:0]); end
    checks++; if (tick !== '0) begin errors++; $display("FAIL restart_tick: got %b want 0", tick); end
    step();
    checks++; if (clock_out[1:0] !== 2'b11) begin errors++; $display("FAIL restart_rise: got %b want 11", clock_out[1:0]); end
    for (int j = 0; j < 15; j++) begin
      step();
      checks++;
      if (clock_out[1] !== ((j + 1) % 5 < 3)) begin
        errors++; $display("FAIL restart_d5 step %0d: got %b want %b", j, clock_out[1], (j + 1) % 5 < 3);
      end
    end
  endtask

  task automatic test_disable();
    step(); step();
    en[2] = 0;
    for (int j = 0; j < 4; j++) begin
      step();
      checks++;
      if ({clock_out[2], tick[2]} !== 2'b00) begin
        errors++; $display("FAIL disable_low %0d: got %b%b want 00", j, clock_out[2], tick[2]);
      end
    end
    cv = 1; cc = 2; cd = 2;
    step();
    cv = 0; en[2] = 1;
    for (int j = 0; j < 8; j++) begin
      step();
      checks++;
      if (clock_out[2] !== (j % 2 == 0)) begin
        errors++; $display("FAIL disable_d2 step %0d: got %b want %b", j, clock_out[2], j % 2 == 0);
      end
    end
  endtask

  task automatic test_reset_pending();
    cv = 1; cc = 3; cd = 7;
    step();
    rst = 1; sr = 1; cv = 1; cc = 3; cd = 9;
    step();
    rst = 0; sr = 0; cv = 0; #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstpend_ready: got %b want 1", cfg_ready); end
    checks++; if (clock_out !== '0) begin errors++; $display("FAIL rstpend_clk: got %b want 0", clock_out); end
    for (int k = 1; k <= 9; k++) begin
      step();
      checks++;
      if (clock_out[3] !== (k % 3 != 0)) begin
        errors++; $display("FAIL rstpend_d3 cyc %0d: got %b want %b", k, clock_out[3], k % 3 != 0);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cv  = 1'($urandom % 2);
      cc  = CW'($urandom_range(0, 7));
      cd  = W'($urandom_range(0, 6));
      sr  = ($urandom % 16) == 0;
      rst = ($urandom % 64) == 0;
      if ($urandom % 8 == 0) en = CH'($urandom);
      step();
      #1;
      checks++;
      if ({clock_out, tick, cfg_err, cfg_ready} !== {e_clk, e_tick, e_err, m_ready()}) begin
        errors++; $display("FAIL random %0d: clk %b/%b tick %b/%b err %b/%b rdy %b/%b", n, clock_out, e_clk, tick, e_tick, cfg_err, e_err, cfg_ready, m_ready());
      end
    end
    rst = 0; sr = 0; cv = 0;
  endtask

  initial begin
    test_reset();
    test_default();
    test_reconfig();
    test_errors();
    test_sync_restart();
    test_disable();
    test_reset_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_divider_bank.md
CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent divider channels (1..16).
REQ-002 Parameter WIDTH, default 23: divisor and counter width in bits.
REQ-003 Parameter DEFAULT_DIV, default 3: divisor loaded into every channel at reset (1..2^WIDTH-1).
REQ-004 clock_in  input  1  sole clock; all logic on rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cfg_valid  input  1  divisor write request.
REQ-007 cfg_ready  output  1  write can be accepted this cycle.
REQ-008 cfg_chan  input  max(1,$clog2(CHANNELS))  target channel of the write.
REQ-009 cfg_div  input  WIDTH  new divisor D.
REQ-010 enable  input  CHANNELS  per-channel run enable.
REQ-011 sync_restart  input  1  phase-align all channels.
REQ-012 clock_out  output  CHANNELS  divided square wave per channel, registered.
REQ-013 tick  output  CHANNELS  one-cycle pulse per output period, registered.
REQ-014 cfg_err  output  1  one-cycle pulse on a rejected write, registered.

Function
REQ-015 Each channel SHALL hold an active divisor D, a pending divisor with pending flag, and a counter cycling 0..D-1.
REQ-016 Enabled channel: counter SHALL increment each cycle and wrap from D-1 to 0.
REQ-017 clock_out[i] SHALL be high while counter < ceil(D/2), low otherwise, one-cycle registered lag; period D cycles, high ceil(D/2), low floor(D/2).
REQ-018 tick[i] SHALL pulse for exactly one cycle, one cycle after each wrap (D-1 to 0); D=1 gives tick and clock_out constantly high.
REQ-019 A write SHALL be accepted when cfg_valid and cfg_ready are both high.
REQ-020 cfg_ready SHALL be low only when cfg_chan addresses an in-range channel whose pending flag is set.
REQ-021 An accepted write with cfg_div=0 or cfg_chan>=CHANNELS SHALL be discarded and pulse cfg_err the next cycle; no channel state changes.
REQ-022 A valid accepted write SHALL load the pending divisor and set the pending flag.
REQ-023 A pending divisor SHALL become active at that channel's next wrap, so the new period starts glitch-free at counter 0; the pending flag clears the same cycle.
REQ-024 Disabled channel: counter held at 0, clock_out and tick low; any pending divisor applied immediately.
REQ-025 Re-enable SHALL start counting from 0, clock_out high one cycle later.
REQ-026 sync_restart SHALL force every counter to 0, apply all pending divisors, and suppress tick that cycle; enable still gates each channel.
REQ-027 A write accepted in the same cycle as sync_restart SHALL become active in that restart.
REQ-028 A write accepted in the same cycle as its channel's wrap SHALL become active at the following wrap.

Reset
REQ-029 On reset: all active divisors=DEFAULT_DIV, pending flags clear, counters 0, clock_out=0, tick=0, cfg_err=0; cfg_ready=1 the cycle after.
REQ-030 Reset asserted mid-period or with writes pending SHALL discard all pending writes and dominate sync_restart and cfg_valid.

Structure
REQ-031 Shared package clock_divider_pkg SHALL hold the default-divisor constant, channel-limit constant and a ceil-half function.
REQ-032 One sub-module, clock_divider_channel (counter, shadow register, output logic), SHALL be instantiated CHANNELS times by generate.

Verification
REQ-033 Reset, enable=all 1, DEFAULT_DIV=3 -> clock_out[0] pattern 1,1,0 repeating from cycle 1 after reset; tick every 3rd cycle.
REQ-034 Write chan 1 D=4 mid-period -> old period completes; then clock_out[1] 1,1,0,0; cfg_ready low for chan 1 until the wrap.
REQ-035 Write cfg_div=0 and cfg_chan=CHANNELS -> cfg_err pulses once per write; all outputs unchanged.
REQ-036 Channels 0/1 at D=3/D=5, pulse sync_restart -> both counters 0; rising edges of clock_out[0] and clock_out[1] coincide the next cycle.
REQ-037 Drop enable[2] mid-period, write D=2, raise enable[2] -> clock_out[2] low while disabled, then 1,0 repeating.
REQ-038 Assert reset with a write pending on chan 3 -> chan 3 resumes at D=3; pending write lost.
